// File: rtl/captura_jogada.sv
// captura_jogada: debounces the player switch bus and presents each stable non-zero pattern once
// as a latched play with a valid/ack handshake; a full release to zero re-arms the capture.
module captura_jogada #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int CONT_LARGURA = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [5:0]              chaves,
  input  logic                    habilita,
  input  logic                    ack,
  output logic                    jogada_valida,
  output logic [5:0]              jogada,
  output logic [CONT_LARGURA-1:0] contador_jogadas,
  output logic [3:0]              db_estado
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  typedef enum logic [3:0] {ESPERA = 4'd0, FILTRA = 4'd1, PENDENTE = 4'd2, SOLTURA = 4'd3} estado_t;
  estado_t                 estado_q;
  logic [5:0]              amostra_q;
  logic [5:0]              jogada_q;
  logic [CW-1:0]           cnt_q;
  logic [CONT_LARGURA-1:0] contador_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ESPERA;
      amostra_q  <= '0;
      jogada_q   <= '0;
      cnt_q      <= '0;
      contador_q <= '0;
    end else begin
      case (estado_q)
        ESPERA: if (habilita && chaves != 6'd0) begin
          amostra_q <= chaves;
          cnt_q     <= '0;
          estado_q  <= FILTRA;
        end
        FILTRA: if (chaves != amostra_q) begin
          cnt_q    <= '0;
          estado_q <= ESPERA;
        end else if (cnt_q == CNT_MAX) begin
          jogada_q   <= amostra_q;
          contador_q <= contador_q + 1'b1;
          cnt_q      <= '0;
          estado_q   <= PENDENTE;
        end else cnt_q <= cnt_q + 1'b1;
        PENDENTE: if (ack) begin
          cnt_q    <= '0;
          estado_q <= SOLTURA;
        end
        SOLTURA: if (chaves != 6'd0) cnt_q <= '0;
        else if (cnt_q == CNT_MAX) begin
          cnt_q    <= '0;
          estado_q <= ESPERA;
        end else cnt_q <= cnt_q + 1'b1;
        default: begin
          cnt_q    <= '0;
          estado_q <= ESPERA;
        end
      endcase
    end
  end
  assign jogada_valida    = (estado_q == PENDENTE);
  assign jogada           = jogada_q;
  assign contador_jogadas = contador_q;
  assign db_estado        = estado_q;
endmodule

// File: tb/tb_captura_jogada.sv
// tb_captura_jogada: randomized and directed stimulus against a run-length reference model,
// with expected plays queued at acceptance and checked by a negedge monitor.
module tb_captura_jogada;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] chaves = 6'd0;
  logic       habilita = 1'b0;
  logic       ack = 1'b0;
  logic       jogada_valida;
  logic [5:0] jogada;
  logic [7:0] contador_jogadas;
  logic [3:0] db_estado;
  int total = 0;
  int bad = 0;
  logic [13:0] sb[$];
  logic       m_rst = 1'b1, m_pend = 1'b0, m_rel = 1'b1, prev_valid = 1'b0;
  logic [5:0] m_cand = 6'd0, m_jog = 6'd0;
  logic [7:0] m_cnt = 8'd0;
  int         m_run = 0, m_zero = 0;

  captura_jogada #(.DEBOUNCE_CICLOS(D), .CONT_LARGURA(8)) dut (
    .clock(clk), .reset(reset), .chaves(chaves), .habilita(habilita), .ack(ack),
    .jogada_valida(jogada_valida), .jogada(jogada), .contador_jogadas(contador_jogadas),
    .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, got, want, $time);
    end
  endtask

  // Reference: a play is a pattern seen on D+1 consecutive samples starting while enabled and
  // re-armed; re-arming needs D consecutive zero samples after the play is acknowledged.
  task automatic model(input logic [5:0] c, input logic h, input logic a, input logic r);
    if (r) begin
      m_rst = 1; m_pend = 0; m_rel = 1; m_run = 0; m_zero = 0; m_jog = 0; m_cnt = 0;
    end else begin
      m_rst = 0;
      if (m_pend) begin
        if (a) begin m_pend = 0; m_rel = 0; m_zero = 0; end
      end else if (!m_rel) begin
        m_zero = (c == 6'd0) ? m_zero + 1 : 0;
        if (m_zero == D) m_rel = 1;
      end else if (m_run == 0) begin
        if (h && c != 6'd0) begin m_cand = c; m_run = 1; end
      end else if (c == m_cand) begin
        m_run++;
        if (m_run == D + 1) begin
          m_jog = m_cand; m_cnt++; m_pend = 1; m_run = 0;
          sb.push_back({m_cand, m_cnt});
        end
      end else m_run = 0;
    end
  endtask

  task automatic step(input logic [5:0] c, input logic h, input logic a, input logic r);
    chaves = c; habilita = h; ack = a; reset = r;
    @(posedge clk);
    model(c, h, a, r);
    #1;
  endtask

  task automatic rep(input int n, input logic [5:0] c, input logic h);
    for (int i = 0; i < n; i++) step(c, h, 1'b0, 1'b0);
  endtask

  task automatic release_play();
    step(6'd0, 1'b1, 1'b1, 1'b0);
    rep(D, 6'd0, 1'b1);
  endtask

  always @(negedge clk) begin
    chk("valid", int'(jogada_valida), int'(m_pend));
    chk("jogada", int'(jogada), int'(m_jog));
    chk("contador", int'(contador_jogadas), int'(m_cnt));
    if (m_rst) chk("db_reset", int'(db_estado), 0);
    if (m_pend) chk("db_pendente", int'(db_estado), 2);
    if (jogada_valida && !prev_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_play", 1, 0);
      else begin
        logic [13:0] e;
        e = sb.pop_front();
        chk("sb_jogada", int'(jogada), int'(e[13:8]));
        chk("sb_contador", int'(contador_jogadas), int'(e[7:0]));
      end
    end
    prev_valid = jogada_valida;
  end

  initial begin
    logic [5:0] c;
    logic       h;
    rep(0, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(6'h3f, 1'b1, 1'b0, 1'b1);
    rep(10, 6'b100001, 1'b1);
    release_play();
    rep(50, 6'b100001, 1'b1);
    step(6'b100001, 1'b1, 1'b1, 1'b0);
    rep(50, 6'b100001, 1'b1);
    rep(3, 6'd0, 1'b1);
    rep(3, 6'b000010, 1'b1);
    rep(4, 6'd0, 1'b1);
    rep(6, 6'b000010, 1'b1);
    release_play();
    rep(2, 6'b000001, 1'b1);
    rep(1, 6'd0, 1'b1);
    rep(7, 6'b000001, 1'b1);
    release_play();
    rep(20, 6'b010000, 1'b0);
    rep(6, 6'b010000, 1'b1);
    step(6'b010000, 1'b1, 1'b0, 1'b1);
    step(6'b010000, 1'b1, 1'b0, 1'b0);
    rep(2, 6'b000100, 1'b1);
    step(6'b000100, 1'b1, 1'b0, 1'b1);
    rep(3, 6'd0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      rep(D + 1, 6'($urandom_range(1, 63)), 1'b1);
      release_play();
    end
    c = 6'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) c = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      h = ($urandom_range(0, 4) != 0);
      step(c, h, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end
    rep(3, 6'd0, 1'b1);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
